axis_iq16_dma_packer: RTL
=========================

// Module: axis_iq16_dma_packer
// PURPOSE
// Downstream of the 2-channel FIR I/Q pairing stage. Consumes the 16-bit {I[15:8],Q[7:0]} AXIS pair stream,
// packs two consecutive pairs into one 32-bit word and frames words into DMA packets of FRAME_WORDS words.
// Output feeds the AXI DMA S2MM slave port. Full AXIS backpressure; no sample is ever dropped.
// PARAMETERS
// FRAME_WORDS  256  32-bit words per DMA packet; legal range 2..65535
// PORTS
// aclk           in   1   clock; all logic on rising edge
// areset         in   1   asynchronous, active-high reset
// s_axis_tdata   in   16  I/Q pair {I,Q}
// s_axis_tvalid  in   1   input valid
// s_axis_tready  out  1   input ready
// s_axis_tlast   in   1   end of upstream burst; forces early packet close
// m_axis_tdata   out  32  packed word {pair_n+1, pair_n}
// m_axis_tkeep   out  4   byte enables; 4'hF full word, 4'h3 half word
// m_axis_tvalid  out  1   output valid
// m_axis_tready  in   1   output ready (DMA)
// m_axis_tlast   out  1   last word of DMA packet
// frame_count    out  16  packets completed (tlast handshakes), wraps at 16'hFFFF->0
// BEHAVIOUR
// - Reset (async, any time): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, frame_count=0,
//   state=S_LO, word_cnt=0, held pair discarded. Mid-frame reset: next accepted pair starts a new word and packet.
// - One output register stage. out_free = !m_axis_tvalid || m_axis_tready.
// - s_axis_tready = out_free (combinational from m_axis_tready; never depends on s_axis_tvalid/tlast).
// - FSM, input handshake = s_axis_tvalid && s_axis_tready:
//   S_LO: handshake, tlast=0 -> lo_reg<=tdata, go S_HI.
//         handshake, tlast=1 -> load output {16'h0,tdata}, tkeep=4'h3, tlast=1, stay S_LO.
//   S_HI: handshake -> load output {tdata,lo_reg}, tkeep=4'hF, go S_LO;
//         tlast = s_axis_tlast || (word_cnt==FRAME_WORDS-1).
// - Latency: word valid on cycle after the handshake that completes it. Throughput 1 pair/clk (1 word per 2 clks).
// - Output load: m_axis_tvalid<=1 on load; else m_axis_tvalid<=0 when m_axis_tready. Load + output handshake same cycle
//   -> new word replaces old, tvalid stays 1. tdata/tkeep/tlast held stable while tvalid && !tready.
// - word_cnt (16 bit): on each word load, 0 if loaded word has tlast, else +1. Never reaches FRAME_WORDS.
// - Early tlast on full word (S_HI) also resets word_cnt; next packet starts full-length.
// - frame_count += 1 on every m_axis_tvalid && m_axis_tready && m_axis_tlast; wraps silently.
// - S_HI with upstream idle: lo pair held indefinitely; no timeout flush (flush only via s_axis_tlast).
// TESTING
// 1 Reset: assert areset async mid-clock -> tvalid=0, tlast=0, frame_count=0 immediately; s_axis_tready=1 after release.
// 2 FRAME_WORDS=4, ready=1, pairs 16'h0001..16'h0008 -> words 32'h00020001,00040003,00060005,00080007;
//   tkeep=F; tlast only on 4th; frame_count=1.
// 3 Backpressure: word pending, m_axis_tready=0 for 5 clks -> tdata stable, s_axis_tready=0, no loss/duplication.
// 4 Early tlast: FRAME_WORDS=4, pairs A1,A2,A3(tlast) -> {A2,A1} tkeep=F tlast=0, {0000,A3} tkeep=3 tlast=1;
//   then 8 pairs -> full 4-word packet, tlast on 4th.
// 5 Reset after lo pair B1 held -> pairs C1,C2 give {C2,C1}; word_cnt restarted (tlast at 4th word after reset).
// 6 Random tvalid/tready 50%, 10k pairs, random tlast 1% -> scoreboard match, AXIS stability assertions clean.

Source files
------------

// File: rtl/axis_iq16_dma_packer.sv
// axis_iq16_dma_packer
// Packs two consecutive 16-bit {I,Q} pairs into one 32-bit AXIS word, with the
// first pair in the low half. Words are grouped into DMA packets of FRAME_WORDS
// words. An upstream tlast closes the current packet early. If tlast arrives on
// the low pair of a word, that word goes out as a half word with tkeep=4'h3.
// There is one registered output stage with full backpressure, so no pair is
// ever dropped.

module axis_iq16_dma_packer #(
  parameter int unsigned FRAME_WORDS = 256
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] frame_count
);

  localparam int unsigned PAIR_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEEP_W = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_WORDS - 1);
  localparam logic [KEEP_W-1:0] KEEP_FULL = 4'hF;
  localparam logic [KEEP_W-1:0] KEEP_HALF = 4'h3;

  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } state_t;

  state_t              state;
  logic [PAIR_W-1:0]   lo_reg;
  logic [CNT_W-1:0]    word_cnt;

  logic                out_free;
  logic                in_hs;
  logic                out_hs;
  logic                frame_end;

  // Output stage can take a new word when empty or draining this cycle
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = out_free;
  assign in_hs         = s_axis_tvalid && out_free;
  assign out_hs        = m_axis_tvalid && m_axis_tready;

  // A full word closes the packet on upstream tlast or on the last word slot
  assign frame_end     = s_axis_tlast || (word_cnt == LAST_IDX);

  // Pair-collection FSM and the output register stage
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= S_LO;
      lo_reg        <= '0;
      word_cnt      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      // The word currently on the output is consumed. A load below overrides this.
      if (out_hs) begin
        m_axis_tvalid <= 1'b0;
      end

      if (in_hs) begin
        case (state)
          S_LO: begin
            if (s_axis_tlast) begin
              // A lone low pair closes the packet as a half word
              m_axis_tdata  <= {PAIR_W'(0), s_axis_tdata};
              m_axis_tkeep  <= KEEP_HALF;
              m_axis_tlast  <= 1'b1;
              m_axis_tvalid <= 1'b1;
              word_cnt      <= '0;
              state         <= S_LO;
            end else begin
              lo_reg        <= s_axis_tdata;
              state         <= S_HI;
            end
          end
          S_HI: begin
            m_axis_tdata  <= WORD_W'({s_axis_tdata, lo_reg});
            m_axis_tkeep  <= KEEP_FULL;
            m_axis_tlast  <= frame_end;
            m_axis_tvalid <= 1'b1;
            word_cnt      <= frame_end ? '0 : word_cnt + CNT_W'(1);
            state         <= S_LO;
          end
          default: begin
            state <= S_LO;
          end
        endcase
      end
    end
  end

  // Completed-packet counter, wraps silently
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_count <= '0;
    end else if (out_hs && m_axis_tlast) begin
      frame_count <= frame_count + CNT_W'(1);
    end
  end

endmodule
